sort_ctrl_8: RTL and testbench

Sequential sort controller for a single shared 8-bit magnitude comparator. It accepts a burst of up to DEPTH bytes over a valid/ready input and bubble-sorts them in an internal buffer using one compare per cycle. It then streams the sorted burst out over a valid/ready output. It is the sequencer in front of `comp_8`: `comp_8` is the only magnitude-compare resource, and every ordering decision goes through it.

---
 rtl/sort_ctrl_8_pkg.sv | 28 ++
 rtl/sort_ctrl_8_if.sv | 30 +++
 rtl/sort_ctrl_8_comp_8.sv | 15 +
 rtl/sort_ctrl_8.sv | 256 +++++++++++++++++++++++++
 tb/tb_sort_ctrl_8.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_ctrl_8_pkg.sv
// sort_pkg: shared types and constants for the sort_ctrl_8 controller.
//   state_t    - controller phases (LOAD, SORT, DRAIN)
//   MAX_DEPTH  - largest burst the index registers must address
//   IDX_W      - width of the cnt / idx / pass / rd registers
//   sat_inc8   - saturating byte increment used by the swap counter
package sort_pkg;

    localparam int MAX_DEPTH = 16;
    localparam int IDX_W     = $clog2(MAX_DEPTH) + 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'h01;
        end
        return r;
    endfunction

endpackage

// File: rtl/sort_ctrl_8_if.sv
// sort_ctrl_8_if: input stream, output stream and status of the sort controller.
//   in_valid/in_ready/in_data/in_last     - burst input, transfer on valid && ready
//   out_valid/out_ready/out_data/out_last - sorted output, transfer on valid && ready
//   busy  - controller is in SORT or DRAIN
//   swaps - swap count of the most recent burst (saturating)
// Modport master is the producer/consumer side, slave is the controller.
interface sort_ctrl_8_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic [7:0] swaps;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, swaps
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, swaps
    );

endinterface

// File: rtl/sort_ctrl_8_comp_8.sv
// comp_8: the single shared 8-bit unsigned magnitude comparator.
//   p, q - bytes under comparison
//   p0   - 1 when p != q
//   p1   - 0 when p > q, 1 otherwise
module comp_8 (
    input  logic [7:0] p,
    input  logic [7:0] q,
    output logic       p0,
    output logic       p1
);

    assign p0 = (p != q) ? 1'b1 : 1'b0;
    assign p1 = (p > q)  ? 1'b0 : 1'b1;

endmodule

// File: rtl/sort_ctrl_8.sv
// sort_ctrl_8: collects a burst of up to DEPTH bytes, bubble-sorts it with one
// comp_8 decision per cycle, then streams the sorted burst out.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - sort_ctrl_8_if.slave (input stream, output stream, busy, swaps)
// Parameters: DEPTH (2..16) maximum burst, ASCEND 1 = ascending, 0 = descending.
module sort_ctrl_8
    import sort_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ASCEND = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sort_ctrl_8_if.slave   bus
);

    localparam logic [IDX_W-1:0] DEPTH_M1 = IDX_W'(DEPTH - 1);
    localparam logic             ASC      = (ASCEND != 0) ? 1'b1 : 1'b0;

    state_t           state;
    state_t           state_next;
    logic [7:0]       mem      [DEPTH];
    logic [7:0]       mem_next [DEPTH];
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_next;
    logic [IDX_W-1:0] n;
    logic [IDX_W-1:0] n_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] pass;
    logic [IDX_W-1:0] pass_next;
    logic [IDX_W-1:0] rd;
    logic [IDX_W-1:0] rd_next;
    logic             pass_swapped;
    logic             pass_swapped_next;
    logic [7:0]       swaps_q;
    logic [7:0]       swaps_next;
    logic             out_valid_q;
    logic             out_valid_next;
    logic [7:0]       out_data_q;
    logic [7:0]       out_data_next;
    logic             out_last_q;
    logic             out_last_next;
    logic             busy_q;

    logic [IDX_W-1:0] idx_p1;
    logic [IDX_W-1:0] n_m1;
    logic [IDX_W-1:0] n_m2;
    logic [IDX_W-1:0] pass_p1;
    logic [7:0]       p_byte;
    logic [7:0]       q_byte;
    logic [7:0]       rd_byte;
    logic             cmp_ne;
    logic             cmp_not_gt;
    logic             swap_now;

    assign idx_p1  = idx + IDX_W'(1);
    assign n_m1    = n - IDX_W'(1);
    assign n_m2    = n - IDX_W'(2);
    assign pass_p1 = pass + IDX_W'(1);

    // Select buf[idx], buf[idx+1] for the comparator and buf[rd] for the drain.
    always_comb begin
        p_byte  = 8'h00;
        q_byte  = 8'h00;
        rd_byte = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            if (idx == IDX_W'(k)) begin
                p_byte = mem[k];
            end else begin
                p_byte = p_byte;
            end
            if (idx_p1 == IDX_W'(k)) begin
                q_byte = mem[k];
            end else begin
                q_byte = q_byte;
            end
            if (rd == IDX_W'(k)) begin
                rd_byte = mem[k];
            end else begin
                rd_byte = rd_byte;
            end
        end
    end

    comp_8 u_comp (
        .p  (p_byte),
        .q  (q_byte),
        .p0 (cmp_ne),
        .p1 (cmp_not_gt)
    );

    // Ascending swaps on P>Q; descending swaps on P<Q. Equal pairs never swap.
    assign swap_now = (state == SORT) &&
                      (ASC ? !cmp_not_gt : (cmp_not_gt && cmp_ne));

    // Next-state and next-register decode for all three phases.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        n_next            = n;
        idx_next          = idx;
        pass_next         = pass;
        rd_next           = rd;
        pass_swapped_next = pass_swapped;
        swaps_next        = swaps_q;
        out_valid_next    = out_valid_q;
        out_data_next     = out_data_q;
        out_last_next     = out_last_q;
        for (int k = 0; k < DEPTH; k++) begin
            mem_next[k] = mem[k];
        end

        case (state)
            LOAD: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (cnt == IDX_W'(k)) begin
                            mem_next[k] = bus.in_data;
                        end else begin
                            mem_next[k] = mem[k];
                        end
                    end
                    cnt_next = cnt + IDX_W'(1);
                    // A full buffer ends the burst even without in_last.
                    if (bus.in_last || (cnt == DEPTH_M1)) begin
                        n_next            = cnt + IDX_W'(1);
                        swaps_next        = 8'h00;
                        idx_next          = '0;
                        pass_next         = '0;
                        pass_swapped_next = 1'b0;
                        if (cnt == '0) begin
                            // One word is trivially sorted; present it directly.
                            state_next     = DRAIN;
                            out_valid_next = 1'b1;
                            out_data_next  = bus.in_data;
                            out_last_next  = 1'b1;
                            rd_next        = IDX_W'(1);
                        end else begin
                            state_next = SORT;
                        end
                    end else begin
                        state_next = LOAD;
                    end
                end else begin
                    cnt_next = cnt;
                end
            end

            SORT: begin
                if (swap_now) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (idx == IDX_W'(k)) begin
                            mem_next[k] = q_byte;
                        end else if (idx_p1 == IDX_W'(k)) begin
                            mem_next[k] = p_byte;
                        end else begin
                            mem_next[k] = mem[k];
                        end
                    end
                    pass_swapped_next = 1'b1;
                    swaps_next        = sat_inc8(swaps_q);
                end else begin
                    pass_swapped_next = pass_swapped;
                end

                if (idx == n_m2) begin
                    // A clean pass or n-1 completed passes leaves the buffer sorted.
                    if (!(pass_swapped || swap_now) || (pass_p1 == n_m1)) begin
                        state_next     = DRAIN;
                        out_valid_next = 1'b1;
                        out_data_next  = mem_next[0];
                        out_last_next  = 1'b0;
                        rd_next        = IDX_W'(1);
                    end else begin
                        idx_next          = '0;
                        pass_next         = pass_p1;
                        pass_swapped_next = 1'b0;
                    end
                end else begin
                    idx_next = idx_p1;
                end
            end

            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        state_next     = LOAD;
                        cnt_next       = '0;
                    end else begin
                        out_data_next = rd_byte;
                        out_last_next = (rd == n_m1) ? 1'b1 : 1'b0;
                        rd_next       = rd + IDX_W'(1);
                    end
                end else begin
                    out_valid_next = out_valid_q;
                end
            end

            default: begin
                state_next     = LOAD;
                cnt_next       = '0;
                out_valid_next = 1'b0;
                out_last_next  = 1'b0;
            end
        endcase
    end

    // State, buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            cnt          <= '0;
            n            <= '0;
            idx          <= '0;
            pass         <= '0;
            rd           <= '0;
            pass_swapped <= 1'b0;
            swaps_q      <= 8'h00;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= 8'h00;
            end
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            n            <= n_next;
            idx          <= idx_next;
            pass         <= pass_next;
            rd           <= rd_next;
            pass_swapped <= pass_swapped_next;
            swaps_q      <= swaps_next;
            out_valid_q  <= out_valid_next;
            out_data_q   <= out_data_next;
            out_last_q   <= out_last_next;
            busy_q       <= (state_next != LOAD) ? 1'b1 : 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= mem_next[k];
            end
        end
    end

    assign bus.in_ready  = (state == LOAD) ? 1'b1 : 1'b0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.swaps     = swaps_q;

endmodule

// File: tb/tb_sort_ctrl_8.sv
// Bench for sort_ctrl_8: an ascending and a descending instance see the same
// input stream; a reference model fills per-instance scoreboards.
module tb_sort_ctrl_8;

    logic clk;
    logic rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    int n_cmp;
    int n_err;

    logic [7:0] burst_buf [16];
    logic [7:0] q_a_data[$];
    bit         q_a_last[$];
    logic [7:0] q_d_data[$];
    bit         q_d_last[$];
    logic [7:0] exp_sw_a;
    logic [7:0] exp_sw_d;

    sort_ctrl_8_if bus_a ();
    sort_ctrl_8_if bus_d ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_d.in_valid  = in_valid;
    assign bus_d.in_data   = in_data;
    assign bus_d.in_last   = in_last;
    assign bus_d.out_ready = out_ready;

    sort_ctrl_8 #(.DEPTH(8), .ASCEND(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sort_ctrl_8 #(.DEPTH(8), .ASCEND(0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every output transfer is checked against the model queue.
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (bus_a.out_valid) begin
                n_cmp++;
                if (q_a_data.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_asc_unexpected: got data %0d with nothing expected", bus_a.out_data);
                end else begin
                    logic [7:0] ed;
                    bit el;
                    ed = q_a_data.pop_front();
                    el = q_a_last.pop_front();
                    if (bus_a.out_data !== ed || bus_a.out_last !== el) begin
                        n_err++;
                        $display("FAIL sb_asc: got data %0d last %0b, expected data %0d last %0b",
                                 bus_a.out_data, bus_a.out_last, ed, el);
                    end
                end
            end
            if (bus_d.out_valid) begin
                n_cmp++;
                if (q_d_data.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_desc_unexpected: got data %0d with nothing expected", bus_d.out_data);
                end else begin
                    logic [7:0] ed;
                    bit el;
                    ed = q_d_data.pop_front();
                    el = q_d_last.pop_front();
                    if (bus_d.out_data !== ed || bus_d.out_last !== el) begin
                        n_err++;
                        $display("FAIL sb_desc: got data %0d last %0b, expected data %0d last %0b",
                                 bus_d.out_data, bus_d.out_last, ed, el);
                    end
                end
            end
        end
    end

    // Reference model: plain sorts plus inversion counts (bubble-sort swap count).
    task automatic model_push(input int len);
        logic [7:0] sa [16];
        logic [7:0] sd [16];
        logic [7:0] t;
        int inv_a;
        int inv_d;
        inv_a = 0;
        inv_d = 0;
        for (int x = 0; x < len; x++) begin
            sa[x] = burst_buf[x];
            sd[x] = burst_buf[x];
            for (int y = x + 1; y < len; y++) begin
                if (burst_buf[x] > burst_buf[y]) inv_a++;
                if (burst_buf[x] < burst_buf[y]) inv_d++;
            end
        end
        for (int x = 1; x < len; x++) begin
            for (int y = x; y > 0; y--) begin
                if (sa[y-1] > sa[y]) begin
                    t = sa[y]; sa[y] = sa[y-1]; sa[y-1] = t;
                end
                if (sd[y-1] < sd[y]) begin
                    t = sd[y]; sd[y] = sd[y-1]; sd[y-1] = t;
                end
            end
        end
        for (int x = 0; x < len; x++) begin
            q_a_data.push_back(sa[x]);
            q_a_last.push_back(x == len - 1);
            q_d_data.push_back(sd[x]);
            q_d_last.push_back(x == len - 1);
        end
        exp_sw_a = (inv_a > 255) ? 8'd255 : 8'(inv_a);
        exp_sw_d = (inv_d > 255) ? 8'd255 : 8'(inv_d);
    endtask

    // Drive one burst, returning #1 after the final accept edge.
    task automatic send_burst(input int len, input bit use_last, input bit push, output bit ok);
        int t;
        ok = 1'b1;
        if (push) model_push(len);
        t = 0;
        while (!(bus_a.in_ready && bus_d.in_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) ok = 1'b0;
        for (int k = 0; k < len; k++) begin
            in_valid = 1'b1;
            in_data  = burst_buf[k];
            in_last  = use_last && (k == len - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while ((bus_a.busy || bus_d.busy || bus_a.out_valid || bus_d.out_valid ||
                q_a_data.size() != 0 || q_d_data.size() != 0) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        ok = (t < 500);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.out_data !== 8'h00 ||
            bus_a.out_last !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.swaps !== 8'h00) begin
            n_err++;
            $display("FAIL reset_asc: rdy %b vld %b data %h last %b busy %b swaps %h, expected 1 0 00 0 0 00",
                     bus_a.in_ready, bus_a.out_valid, bus_a.out_data, bus_a.out_last, bus_a.busy, bus_a.swaps);
        end
        n_cmp++;
        if (bus_d.in_ready !== 1'b1 || bus_d.out_valid !== 1'b0 || bus_d.busy !== 1'b0 || bus_d.swaps !== 8'h00) begin
            n_err++;
            $display("FAIL reset_desc: rdy %b vld %b busy %b swaps %h, expected 1 0 0 00",
                     bus_d.in_ready, bus_d.out_valid, bus_d.busy, bus_d.swaps);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        burst_buf[0] = 8'd5; burst_buf[1] = 8'd3; burst_buf[2] = 8'd9; burst_buf[3] = 8'd1;
        send_burst(4, 1'b1, 1'b1, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL basic_send: in_ready timeout, expected ready"); end
        n_cmp++;
        if (bus_a.in_ready !== 1'b0 || bus_a.busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_rdy_fall: in_ready %b busy %b, expected 0 1", bus_a.in_ready, bus_a.busy);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL basic_idle: timeout, expected drained"); end
        n_cmp++;
        if (bus_a.swaps !== 8'd4 || bus_d.swaps !== exp_sw_d) begin
            n_err++;
            $display("FAIL basic_swaps: asc %0d desc %0d, expected 4 %0d", bus_a.swaps, bus_d.swaps, exp_sw_d);
        end
    endtask

    task automatic test_sorted_implicit();
        bit ok;
        int k;
        for (int x = 0; x < 8; x++) burst_buf[x] = 8'(x + 1);
        send_burst(8, 1'b0, 1'b1, ok);
        n_cmp++;
        if (!ok || bus_a.busy !== 1'b1) begin
            n_err++;
            $display("FAIL implicit_last: busy %b ok %b, expected busy 1", bus_a.busy, ok);
        end
        k = 0;
        while (!bus_a.out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k != 7) begin
            n_err++;
            $display("FAIL sorted_sort_cycles: %0d cycles, expected 7", k);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok || bus_a.swaps !== 8'd0 || bus_d.swaps !== exp_sw_d) begin
            n_err++;
            $display("FAIL sorted_swaps: asc %0d desc %0d ok %b, expected 0 %0d", bus_a.swaps, bus_d.swaps, ok, exp_sw_d);
        end
    endtask

    task automatic test_desc_equal();
        bit ok;
        burst_buf[0] = 8'd7; burst_buf[1] = 8'd7; burst_buf[2] = 8'd2; burst_buf[3] = 8'd7;
        send_burst(4, 1'b1, 1'b1, ok);
        wait_idle(ok);
        n_cmp++;
        if (!ok || bus_d.swaps !== 8'd1 || bus_a.swaps !== exp_sw_a) begin
            n_err++;
            $display("FAIL desc_equal_swaps: desc %0d asc %0d ok %b, expected 1 %0d", bus_d.swaps, bus_a.swaps, ok, exp_sw_a);
        end
    endtask

    task automatic test_single();
        bit ok;
        burst_buf[0] = 8'hAA;
        send_burst(1, 1'b1, 1'b1, ok);
        n_cmp++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'hAA || bus_a.out_last !== 1'b1 || bus_a.swaps !== 8'd0) begin
            n_err++;
            $display("FAIL single_direct: vld %b data %h last %b swaps %0d, expected 1 aa 1 0",
                     bus_a.out_valid, bus_a.out_data, bus_a.out_last, bus_a.swaps);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_rdy_rise: in_ready %b vld %b, expected 1 0", bus_a.in_ready, bus_a.out_valid);
        end
        wait_idle(ok);
    endtask

    task automatic test_backpressure();
        bit ok;
        int t;
        out_ready = 1'b0;
        burst_buf[0] = 8'd0; burst_buf[1] = 8'd255;
        send_burst(2, 1'b1, 1'b1, ok);
        t = 0;
        while (!(bus_a.out_valid && bus_d.out_valid) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (t >= 50) begin n_err++; $display("FAIL bp_valid: timeout, expected out_valid"); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'd0 || bus_a.in_ready !== 1'b0 ||
                bus_d.out_data !== 8'd255 || bus_d.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold: asc vld %b data %0d rdy %b desc vld %b data %0d, expected 1 0 0 1 255",
                         bus_a.out_valid, bus_a.out_data, bus_a.in_ready, bus_d.out_valid, bus_d.out_data);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus_a.in_ready !== 1'b0 || bus_a.out_last !== 1'b1) begin
            n_err++;
            $display("FAIL bp_last_pending: in_ready %b last %b, expected 0 1", bus_a.in_ready, bus_a.out_last);
        end
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_idle: timeout, expected drained"); end
    endtask

    task automatic test_reset_mid_sort();
        bit ok;
        for (int x = 0; x < 6; x++) burst_buf[x] = 8'(6 - x);
        send_burst(6, 1'b1, 1'b0, ok);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.busy !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.swaps !== 8'd0 || bus_a.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midsort_reset: busy %b rdy %b swaps %0d vld %b, expected 0 1 0 0",
                     bus_a.busy, bus_a.in_ready, bus_a.swaps, bus_a.out_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        burst_buf[0] = 8'd4; burst_buf[1] = 8'd2;
        send_burst(2, 1'b1, 1'b1, ok);
        wait_idle(ok);
        n_cmp++;
        if (!ok || bus_a.swaps !== 8'd1 || bus_d.swaps !== exp_sw_d) begin
            n_err++;
            $display("FAIL midsort_next: asc %0d desc %0d ok %b, expected 1 %0d", bus_a.swaps, bus_d.swaps, ok, exp_sw_d);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            for (int x = 0; x < 8; x++) burst_buf[x] = 8'($urandom_range(0, 255));
            send_burst(3 + r, 1'b1, 1'b1, ok);
            wait_idle(ok);
            n_cmp++;
            if (!ok || bus_a.swaps !== exp_sw_a || bus_d.swaps !== exp_sw_d) begin
                n_err++;
                $display("FAIL b2b_swaps: asc %0d desc %0d ok %b, expected %0d %0d",
                         bus_a.swaps, bus_d.swaps, ok, exp_sw_a, exp_sw_d);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        test_reset();
        test_basic();
        test_sorted_implicit();
        test_desc_equal();
        test_single();
        test_backpressure();
        test_reset_mid_sort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
